cache_cmd_sequencer: RTL and testbench

CACHE_CMD_SEQUENCER -- requirements
Module: cache_cmd_sequencer

---
 rtl/cache_pkg.sv | 41 ++++
 rtl/cache_stat_counter.sv | 34 +++
 rtl/cache_cmd_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_cache_cmd_sequencer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, command codes, bus operations and MESI encodings for the
// cache command sequencer and its helpers.
package cache_pkg;

  localparam int CACHE_ADDR_BITS   = 32;
  localparam int CACHE_INDEX_BITS  = 14;
  localparam int CACHE_OFFSET_BITS = 6;
  localparam int CACHE_TAG_BITS    = CACHE_ADDR_BITS - CACHE_INDEX_BITS - CACHE_OFFSET_BITS;

  typedef enum logic [3:0] {
    CMD_RD_D      = 4'd0,
    CMD_WR_D      = 4'd1,
    CMD_RD_I      = 4'd2,
    CMD_SNP_INVAL = 4'd3,
    CMD_SNP_RD    = 4'd4,
    CMD_SNP_WR    = 4'd5,
    CMD_SNP_RDX   = 4'd6,
    CMD_CLEAR     = 4'd8,
    CMD_PRINT     = 4'd9
  } cmd_e;

  typedef enum logic [1:0] {
    BUS_READ       = 2'd0,
    BUS_RFO        = 2'd1,
    BUS_WRITEBACK  = 2'd2,
    BUS_INVALIDATE = 2'd3
  } bus_op_e;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  // Commands 0..6 go through the tag array; 8/9 are set sweeps.
  function automatic logic cmd_needs_lookup(input logic [3:0] cmd);
    return (cmd <= 4'd6);
  endfunction

endpackage

// File: rtl/cache_stat_counter.sv
// 32-bit statistics counter with synchronous clear and saturating increment.
module cache_stat_counter
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rstb,
  input  logic        clear,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_cmd_sequencer.sv
// Trace-driven cache command sequencer: accepts one command at a time, looks it
// up in the tag array, issues the MESI bus traffic it implies and commits it.
module cache_cmd_sequencer
  import cache_pkg::*;
#(
  parameter  int INDEX_BITS  = CACHE_INDEX_BITS,
  parameter  int OFFSET_BITS = CACHE_OFFSET_BITS,
  localparam int TAG_BITS    = CACHE_TAG_BITS + (CACHE_INDEX_BITS - INDEX_BITS)
                               + (CACHE_OFFSET_BITS - OFFSET_BITS)
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_n,
  input  logic [31:0]           cmd_addr,
  output logic                  lookup_valid,
  output logic [INDEX_BITS-1:0] lookup_index,
  output logic [TAG_BITS-1:0]   lookup_tag,
  output logic [3:0]            lookup_op,
  input  logic                  lookup_done,
  input  logic                  lookup_hit,
  input  logic [1:0]            lookup_mesi,
  input  logic [TAG_BITS-1:0]   lookup_victim_tag,
  output logic                  bus_req_valid,
  output logic [1:0]            bus_req_op,
  output logic [31:0]           bus_req_addr,
  input  logic                  bus_req_ready,
  output logic                  update_valid,
  output logic                  update_hit,
  output logic                  clear_valid,
  output logic                  print_valid,
  output logic [INDEX_BITS-1:0] sweep_index,
  output logic                  busy,
  output logic                  err_cmd,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
);

  localparam int NUM_SETS = 2 ** INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(NUM_SETS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_WB, S_FETCH, S_INVAL, S_FLUSH, S_COMMIT, S_SWEEP_CLR, S_SWEEP_PRT
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cmd_q, cmd_d;
  logic [31:0]           addr_q, addr_d;
  logic                  hit_q, hit_d;
  logic [TAG_BITS-1:0]   vtag_q, vtag_d;
  logic [INDEX_BITS-1:0] sweep_q, sweep_d;
  logic                  err_q, err_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic                  lookup_valid_q, lookup_valid_d;
  logic                  bus_valid_q, bus_valid_d;
  logic [1:0]            bus_op_q, bus_op_d;
  logic [31:0]           bus_addr_q, bus_addr_d;
  logic                  update_valid_q, update_valid_d;
  logic                  update_hit_q, update_hit_d;
  logic                  clear_valid_q, clear_valid_d;
  logic                  print_valid_q, print_valid_d;
  logic                  offset_unused;

  assign offset_unused = ^addr_q[OFFSET_BITS-1:0];

  // Outputs are computed from the next state so they are flops aligned with it.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    hit_d   = hit_q;
    vtag_d  = vtag_q;
    sweep_d = sweep_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_d  = cmd_n;
          addr_d = cmd_addr;
          if (cmd_needs_lookup(cmd_n)) begin
            state_d = S_LOOKUP;
          end else if (cmd_n == CMD_CLEAR) begin
            state_d = S_SWEEP_CLR;
            sweep_d = '0;
          end else if (cmd_n == CMD_PRINT) begin
            state_d = S_SWEEP_PRT;
            sweep_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOOKUP: begin
        if (lookup_done) begin
          hit_d  = lookup_hit;
          vtag_d = lookup_victim_tag;
          case (cmd_q)
            CMD_RD_D, CMD_RD_I: begin
              if (lookup_hit)                  state_d = S_COMMIT;
              else if (lookup_mesi == MESI_M)  state_d = S_WB;
              else                             state_d = S_FETCH;
            end
            CMD_WR_D: begin
              if (lookup_hit)                  state_d = (lookup_mesi == MESI_S) ? S_INVAL : S_COMMIT;
              else if (lookup_mesi == MESI_M)  state_d = S_WB;
              else                             state_d = S_FETCH;
            end
            CMD_SNP_RD, CMD_SNP_RDX: begin
              state_d = (lookup_hit && (lookup_mesi == MESI_M)) ? S_FLUSH : S_COMMIT;
            end
            default: state_d = S_COMMIT;
          endcase
        end
      end
      S_WB: begin
        if (bus_req_ready) state_d = S_FETCH;
      end
      S_FETCH, S_INVAL, S_FLUSH: begin
        if (bus_req_ready) state_d = S_COMMIT;
      end
      S_COMMIT: state_d = S_IDLE;
      S_SWEEP_CLR, S_SWEEP_PRT: begin
        if (sweep_q == LAST_INDEX) begin
          state_d = S_IDLE;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + INDEX_BITS'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d    = (state_d == S_IDLE);
    busy_d         = (state_d != S_IDLE);
    lookup_valid_d = (state_d == S_LOOKUP);
    update_valid_d = (state_d == S_COMMIT);
    update_hit_d   = (state_d == S_COMMIT) && hit_d;
    clear_valid_d  = (state_d == S_SWEEP_CLR);
    print_valid_d  = (state_d == S_SWEEP_PRT);
    bus_valid_d    = (state_d == S_WB) || (state_d == S_FETCH) ||
                     (state_d == S_INVAL) || (state_d == S_FLUSH);

    bus_op_d   = BUS_READ;
    bus_addr_d = '0;
    case (state_d)
      S_WB: begin
        bus_op_d   = BUS_WRITEBACK;
        bus_addr_d = {vtag_d, addr_d[OFFSET_BITS +: INDEX_BITS], {OFFSET_BITS{1'b0}}};
      end
      S_FETCH: begin
        bus_op_d   = (cmd_d == CMD_WR_D) ? BUS_RFO : BUS_READ;
        bus_addr_d = {addr_d[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      end
      S_INVAL: begin
        bus_op_d   = BUS_INVALIDATE;
        bus_addr_d = {addr_d[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      end
      S_FLUSH: begin
        bus_op_d   = BUS_WRITEBACK;
        bus_addr_d = {addr_d[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q        <= S_IDLE;
      cmd_q          <= '0;
      addr_q         <= '0;
      hit_q          <= 1'b0;
      vtag_q         <= '0;
      sweep_q        <= '0;
      err_q          <= 1'b0;
      cmd_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      lookup_valid_q <= 1'b0;
      bus_valid_q    <= 1'b0;
      bus_op_q       <= '0;
      bus_addr_q     <= '0;
      update_valid_q <= 1'b0;
      update_hit_q   <= 1'b0;
      clear_valid_q  <= 1'b0;
      print_valid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      addr_q         <= addr_d;
      hit_q          <= hit_d;
      vtag_q         <= vtag_d;
      sweep_q        <= sweep_d;
      err_q          <= err_d;
      cmd_ready_q    <= cmd_ready_d;
      busy_q         <= busy_d;
      lookup_valid_q <= lookup_valid_d;
      bus_valid_q    <= bus_valid_d;
      bus_op_q       <= bus_op_d;
      bus_addr_q     <= bus_addr_d;
      update_valid_q <= update_valid_d;
      update_hit_q   <= update_hit_d;
      clear_valid_q  <= clear_valid_d;
      print_valid_q  <= print_valid_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign err_cmd       = err_q;
  assign lookup_valid  = lookup_valid_q;
  assign lookup_index  = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign lookup_tag    = addr_q[31 -: TAG_BITS];
  assign lookup_op     = cmd_q;
  assign bus_req_valid = bus_valid_q;
  assign bus_req_op    = bus_op_q;
  assign bus_req_addr  = bus_addr_q;
  assign update_valid  = update_valid_q;
  assign update_hit    = update_hit_q;
  assign clear_valid   = clear_valid_q;
  assign print_valid   = print_valid_q;
  assign sweep_index   = sweep_q;

  // Only data-side commands (0/1/2) are counted, on their commit cycle.
  logic data_commit;
  logic inc_reads;
  logic inc_writes;

  assign data_commit = update_valid_q &&
                       ((cmd_q == CMD_RD_D) || (cmd_q == CMD_WR_D) || (cmd_q == CMD_RD_I));
  assign inc_reads   = update_valid_q && ((cmd_q == CMD_RD_D) || (cmd_q == CMD_RD_I));
  assign inc_writes  = update_valid_q && (cmd_q == CMD_WR_D);

  cache_stat_counter u_stat_reads (
    .clk(clk), .rstb(rstb), .clear(clear_valid_q), .inc(inc_reads), .count(stat_reads)
  );
  cache_stat_counter u_stat_writes (
    .clk(clk), .rstb(rstb), .clear(clear_valid_q), .inc(inc_writes), .count(stat_writes)
  );
  cache_stat_counter u_stat_hits (
    .clk(clk), .rstb(rstb), .clear(clear_valid_q), .inc(data_commit && hit_q), .count(stat_hits)
  );
  cache_stat_counter u_stat_misses (
    .clk(clk), .rstb(rstb), .clear(clear_valid_q), .inc(data_commit && !hit_q), .count(stat_misses)
  );

endmodule

// File: tb/tb_cache_cmd_sequencer.sv
// Randomised self-checking bench for cache_cmd_sequencer against a transaction-level
// model of the expected bus traffic, commit behaviour and statistics.
module tb_cache_cmd_sequencer;

  localparam int IB    = 3;
  localparam int OB    = 6;
  localparam int TBITS = 32 - IB - OB;
  localparam int NSETS = 1 << IB;

  logic             clk;
  logic             rstb;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_n;
  logic [31:0]      cmd_addr;
  logic             lookup_valid;
  logic [IB-1:0]    lookup_index;
  logic [TBITS-1:0] lookup_tag;
  logic [3:0]       lookup_op;
  logic             lookup_done;
  logic             lookup_hit;
  logic [1:0]       lookup_mesi;
  logic [TBITS-1:0] lookup_victim_tag;
  logic             bus_req_valid;
  logic [1:0]       bus_req_op;
  logic [31:0]      bus_req_addr;
  logic             bus_req_ready;
  logic             update_valid;
  logic             update_hit;
  logic             clear_valid;
  logic             print_valid;
  logic [IB-1:0]    sweep_index;
  logic             busy;
  logic             err_cmd;
  logic [31:0]      stat_reads;
  logic [31:0]      stat_writes;
  logic [31:0]      stat_hits;
  logic [31:0]      stat_misses;

  cache_cmd_sequencer #(.INDEX_BITS(IB), .OFFSET_BITS(OB)) dut (
    .clk(clk), .rstb(rstb),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_n(cmd_n), .cmd_addr(cmd_addr),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index), .lookup_tag(lookup_tag),
    .lookup_op(lookup_op), .lookup_done(lookup_done), .lookup_hit(lookup_hit),
    .lookup_mesi(lookup_mesi), .lookup_victim_tag(lookup_victim_tag),
    .bus_req_valid(bus_req_valid), .bus_req_op(bus_req_op), .bus_req_addr(bus_req_addr),
    .bus_req_ready(bus_req_ready), .update_valid(update_valid), .update_hit(update_hit),
    .clear_valid(clear_valid), .print_valid(print_valid), .sweep_index(sweep_index),
    .busy(busy), .err_cmd(err_cmd),
    .stat_reads(stat_reads), .stat_writes(stat_writes),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [31:0] m_reads  = '0;
  logic [31:0] m_writes = '0;
  logic [31:0] m_hits   = '0;
  logic [31:0] m_misses = '0;
  logic [33:0] exp_bus[$];

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  // Expected bus transfers ({op, addr}) and counter effects of one command.
  task automatic model_cmd(input logic [3:0] c, input logic [31:0] a, input logic h,
                           input logic [1:0] m, input logic [TBITS-1:0] vt);
    logic [31:0] line_addr;
    logic [31:0] wb_addr;
    exp_bus.delete();
    line_addr = (a >> OB) << OB;
    wb_addr   = (32'(vt) << (IB + OB)) | (((a >> OB) % NSETS) << OB);
    case (c)
      4'd0, 4'd2: begin
        if (!h) begin
          if (m == 2'd3) exp_bus.push_back({2'd2, wb_addr});
          exp_bus.push_back({2'd0, line_addr});
        end
      end
      4'd1: begin
        if (h) begin
          if (m == 2'd1) exp_bus.push_back({2'd3, line_addr});
        end else begin
          if (m == 2'd3) exp_bus.push_back({2'd2, wb_addr});
          exp_bus.push_back({2'd1, line_addr});
        end
      end
      4'd4, 4'd6: if (h && m == 2'd3) exp_bus.push_back({2'd2, line_addr});
      default: ;
    endcase
    if (c == 4'd0 || c == 4'd2) m_reads = sat_inc(m_reads);
    if (c == 4'd1) m_writes = sat_inc(m_writes);
    if (c <= 4'd2) begin
      if (h) m_hits = sat_inc(m_hits);
      else   m_misses = sat_inc(m_misses);
    end
  endtask

  // Drives one lookup command to completion, answering the array and bus as told.
  task automatic run_cmd(input logic [3:0] c, input logic [31:0] a, input logic h,
                         input logic [1:0] m, input logic [TBITS-1:0] vt,
                         input int lk_delay, input int rdy_delay, input string name,
                         output int first_hold, output int upd_cyc, output int done_cyc);
    int cyc, lk_cnt, hold, upd_cnt, nbus;
    bit done;
    logic [33:0] got;
    cyc = 0; lk_cnt = 0; hold = 0; upd_cnt = 0; nbus = 0; done = 0;
    first_hold = 0; upd_cyc = -1; done_cyc = -1;
    model_cmd(c, a, h, m, vt);
    lookup_hit = h; lookup_mesi = m; lookup_victim_tag = vt;
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL %s accept_ready: got %b expected 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_n = c; cmd_addr = a;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_n = 4'($urandom); cmd_addr = $urandom;
    cyc = 1;
    while (!done && cyc < 300) begin
      if (lookup_valid === 1'b1) begin
        checks++;
        if (lookup_index !== IB'((a >> OB) % NSETS)) begin
          fails++; $display("[TB] FAIL %s lookup_index: got %0h expected %0h", name, lookup_index, (a >> OB) % NSETS);
        end
        checks++;
        if (lookup_tag !== TBITS'(a >> (IB + OB))) begin
          fails++; $display("[TB] FAIL %s lookup_tag: got %0h expected %0h", name, lookup_tag, a >> (IB + OB));
        end
        checks++;
        if (lookup_op !== c) begin
          fails++; $display("[TB] FAIL %s lookup_op: got %0d expected %0d", name, lookup_op, c);
        end
        lookup_done = (lk_cnt == lk_delay);
        lk_cnt++;
      end else begin
        lookup_done = 1'b0;
      end
      if (bus_req_valid === 1'b1) begin
        got = {bus_req_op, bus_req_addr};
        hold++;
        checks++;
        if (exp_bus.size() == 0) begin
          fails++; $display("[TB] FAIL %s bus_unexpected: got %0h expected no request", name, got);
        end else if (got !== exp_bus[0]) begin
          fails++; $display("[TB] FAIL %s bus_req: got %0h expected %0h", name, got, exp_bus[0]);
        end
        if (rdy_delay < 0) bus_req_ready = ($urandom_range(0, 2) != 0);
        else               bus_req_ready = (hold > rdy_delay);
        if (bus_req_ready) begin
          if (nbus == 0) first_hold = hold;
          nbus++;
          hold = 0;
          if (exp_bus.size() > 0) void'(exp_bus.pop_front());
        end
      end else begin
        bus_req_ready = 1'b0;
      end
      if (update_valid === 1'b1) begin
        upd_cnt++;
        upd_cyc = cyc;
        checks++;
        if (update_hit !== h) begin
          fails++; $display("[TB] FAIL %s update_hit: got %b expected %b", name, update_hit, h);
        end
      end
      checks++;
      if ((lookup_valid || bus_req_valid || update_valid) && busy !== 1'b1) begin
        fails++; $display("[TB] FAIL %s busy: got %b expected 1", name, busy);
      end
      checks++;
      if ({err_cmd, clear_valid, print_valid} !== 3'b000) begin
        fails++; $display("[TB] FAIL %s stray_strobe: got %b expected 000", name, {err_cmd, clear_valid, print_valid});
      end
      if (upd_cnt > 0 && cmd_ready === 1'b1) begin
        done = 1;
        done_cyc = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    lookup_done = 1'b0; bus_req_ready = 1'b0;
    checks++;
    if (!done) begin
      fails++; $display("[TB] FAIL %s timeout: got no completion expected completion within 300 cycles", name);
    end
    checks++;
    if (upd_cnt != 1) begin
      fails++; $display("[TB] FAIL %s update_count: got %0d expected 1", name, upd_cnt);
    end
    checks++;
    if (exp_bus.size() != 0) begin
      fails++; $display("[TB] FAIL %s bus_missing: got %0d outstanding expected 0", name, exp_bus.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++; $display("[TB] FAIL %s busy_idle: got %b expected 0", name, busy);
    end
    checks++;
    if ({stat_reads, stat_writes, stat_hits, stat_misses} !== {m_reads, m_writes, m_hits, m_misses}) begin
      fails++;
      $display("[TB] FAIL %s stats: got r%0d w%0d h%0d m%0d expected r%0d w%0d h%0d m%0d", name,
               stat_reads, stat_writes, stat_hits, stat_misses, m_reads, m_writes, m_hits, m_misses);
    end
  endtask

  task automatic test_reset;
    rstb = 1'b1;
    #1 rstb = 1'b0;
    #2;
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    end
    checks++;
    if ({busy, err_cmd, lookup_valid, bus_req_valid, update_valid, update_hit, clear_valid, print_valid} !== 8'h00) begin
      fails++; $display("[TB] FAIL reset_strobes: got %b expected 00000000",
                        {busy, err_cmd, lookup_valid, bus_req_valid, update_valid, update_hit, clear_valid, print_valid});
    end
    checks++;
    if ({bus_req_op, bus_req_addr, sweep_index, lookup_index, lookup_op} !== '0) begin
      fails++; $display("[TB] FAIL reset_fields: got op%0h addr%0h sweep%0h idx%0h lop%0h expected all 0",
                        bus_req_op, bus_req_addr, sweep_index, lookup_index, lookup_op);
    end
    checks++;
    if ({stat_reads, stat_writes, stat_hits, stat_misses} !== 128'd0) begin
      fails++; $display("[TB] FAIL reset_stats: got r%0d w%0d h%0d m%0d expected 0", stat_reads, stat_writes, stat_hits, stat_misses);
    end
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_hit;
    int fh, uc, dc;
    run_cmd(4'd0, 32'h0000_1040, 1'b1, 2'd2, '0, 0, 0, "read_hit", fh, uc, dc);
    checks++;
    if (uc != 2) begin
      fails++; $display("[TB] FAIL read_hit_update_cycle: got %0d expected 2", uc);
    end
    checks++;
    if (dc != 3) begin
      fails++; $display("[TB] FAIL read_hit_ready_cycle: got %0d expected 3", dc);
    end
  endtask

  task automatic test_write_miss_wb;
    int fh, uc, dc;
    run_cmd(4'd1, 32'h0000_1040, 1'b0, 2'd3, TBITS'(12'h0AB), 1, 3, "write_miss_wb", fh, uc, dc);
    checks++;
    if (fh != 4) begin
      fails++; $display("[TB] FAIL write_miss_wb_hold: got %0d cycles expected 4", fh);
    end
    run_cmd(4'd2, 32'h1234_5678, 1'b0, 2'd1, TBITS'(5), 0, 1, "ifetch_miss_clean", fh, uc, dc);
    run_cmd(4'd1, 32'hCAFE_0080, 1'b1, 2'd1, '0, 2, 0, "write_hit_shared", fh, uc, dc);
  endtask

  task automatic test_snoop;
    int fh, uc, dc;
    run_cmd(4'd6, 32'hDEAD_BEEF, 1'b1, 2'd3, '0, 0, 1, "snoop_rdx_m", fh, uc, dc);
    run_cmd(4'd5, 32'h0BAD_F00D, 1'b1, 2'd3, '0, 0, 0, "snoop_wr", fh, uc, dc);
    run_cmd(4'd4, 32'h0000_2FC0, 1'b1, 2'd1, '0, 1, 0, "snoop_rd_s", fh, uc, dc);
    run_cmd(4'd3, 32'h7777_0000, 1'b0, 2'd0, '0, 0, 0, "snoop_inval", fh, uc, dc);
  endtask

  task automatic test_illegal;
    logic [3:0] bad [7];
    bad = '{4'd7, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    for (int i = 0; i < 7; i++) begin
      cmd_valid = 1'b1; cmd_n = bad[i]; cmd_addr = $urandom;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (err_cmd !== 1'b1) begin
        fails++; $display("[TB] FAIL illegal_err_pulse cmd %0d: got %b expected 1", bad[i], err_cmd);
      end
      checks++;
      if ({cmd_ready, busy, lookup_valid, bus_req_valid, update_valid} !== 5'b10000) begin
        fails++; $display("[TB] FAIL illegal_idle cmd %0d: got %b expected 10000", bad[i],
                          {cmd_ready, busy, lookup_valid, bus_req_valid, update_valid});
      end
      @(negedge clk);
      checks++;
      if (err_cmd !== 1'b0) begin
        fails++; $display("[TB] FAIL illegal_err_width cmd %0d: got %b expected 0", bad[i], err_cmd);
      end
    end
    checks++;
    if ({stat_reads, stat_writes, stat_hits, stat_misses} !== {m_reads, m_writes, m_hits, m_misses}) begin
      fails++; $display("[TB] FAIL illegal_stats: got r%0d w%0d h%0d m%0d expected r%0d w%0d h%0d m%0d",
                        stat_reads, stat_writes, stat_hits, stat_misses, m_reads, m_writes, m_hits, m_misses);
    end
  endtask

  task automatic test_sweep(input bit is_clear);
    string name;
    name = is_clear ? "sweep_clear" : "sweep_print";
    cmd_valid = 1'b1; cmd_n = is_clear ? 4'd8 : 4'd9; cmd_addr = $urandom;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < NSETS; i++) begin
      checks++;
      if ({clear_valid, print_valid} !== (is_clear ? 2'b10 : 2'b01)) begin
        fails++; $display("[TB] FAIL %s strobe step %0d: got %b expected %b", name, i,
                          {clear_valid, print_valid}, is_clear ? 2'b10 : 2'b01);
      end
      checks++;
      if (sweep_index !== IB'(i)) begin
        fails++; $display("[TB] FAIL %s sweep_index: got %0d expected %0d", name, sweep_index, i);
      end
      checks++;
      if ({cmd_ready, busy, bus_req_valid, update_valid} !== 4'b0100) begin
        fails++; $display("[TB] FAIL %s busy_state step %0d: got %b expected 0100", name, i,
                          {cmd_ready, busy, bus_req_valid, update_valid});
      end
      @(negedge clk);
    end
    checks++;
    if ({clear_valid, print_valid, cmd_ready} !== 3'b001) begin
      fails++; $display("[TB] FAIL %s end: got %b expected 001", name, {clear_valid, print_valid, cmd_ready});
    end
    if (is_clear) begin
      m_reads = '0; m_writes = '0; m_hits = '0; m_misses = '0;
    end
    checks++;
    if ({stat_reads, stat_writes, stat_hits, stat_misses} !== {m_reads, m_writes, m_hits, m_misses}) begin
      fails++; $display("[TB] FAIL %s stats: got r%0d w%0d h%0d m%0d expected r%0d w%0d h%0d m%0d", name,
                        stat_reads, stat_writes, stat_hits, stat_misses, m_reads, m_writes, m_hits, m_misses);
    end
  endtask

  task automatic test_random;
    int fh, uc, dc;
    logic [3:0] c;
    logic h;
    logic [1:0] m;
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 6));
      h = 1'($urandom_range(0, 1));
      m = h ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
      run_cmd(c, $urandom, h, m, TBITS'($urandom), $urandom_range(0, 3), -1, "random", fh, uc, dc);
    end
  endtask

  task automatic test_reset_mid;
    int fh, uc, dc;
    lookup_hit = 1'b0; lookup_mesi = 2'd0;
    cmd_valid = 1'b1; cmd_n = 4'd0; cmd_addr = 32'h0000_5540;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (lookup_valid !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_mid_lookup: got %b expected 1", lookup_valid);
    end
    lookup_done = 1'b1;
    @(negedge clk);
    lookup_done = 1'b0;
    checks++;
    if ({bus_req_valid, bus_req_op, bus_req_addr} !== {1'b1, 2'd0, 32'h0000_5540}) begin
      fails++; $display("[TB] FAIL reset_mid_fetch: got v%b op%0d addr%0h expected v1 op0 addr5540",
                        bus_req_valid, bus_req_op, bus_req_addr);
    end
    repeat (2) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    checks++;
    if ({bus_req_valid, cmd_ready, busy, update_valid} !== 4'b0100) begin
      fails++; $display("[TB] FAIL reset_mid_abort: got %b expected 0100", {bus_req_valid, cmd_ready, busy, update_valid});
    end
    @(negedge clk);
    rstb = 1'b1;
    m_reads = '0; m_writes = '0; m_hits = '0; m_misses = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({update_valid, bus_req_valid, cmd_ready} !== 3'b001) begin
        fails++; $display("[TB] FAIL reset_mid_quiet cycle %0d: got %b expected 001", i, {update_valid, bus_req_valid, cmd_ready});
      end
    end
    checks++;
    if ({stat_reads, stat_writes, stat_hits, stat_misses} !== 128'd0) begin
      fails++; $display("[TB] FAIL reset_mid_stats: got r%0d w%0d h%0d m%0d expected 0", stat_reads, stat_writes, stat_hits, stat_misses);
    end
    run_cmd(4'd2, 32'h0000_00C0, 1'b1, 2'd2, '0, 0, 0, "after_reset", fh, uc, dc);
  endtask

  initial begin
    rstb = 1'b1; cmd_valid = 1'b0; cmd_n = '0; cmd_addr = '0;
    lookup_done = 1'b0; lookup_hit = 1'b0; lookup_mesi = '0; lookup_victim_tag = '0;
    bus_req_ready = 1'b0;
    test_reset;
    test_read_hit;
    test_write_miss_wb;
    test_snoop;
    test_illegal;
    test_sweep(1'b0);
    test_sweep(1'b1);
    test_random;
    test_sweep(1'b0);
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
